// File: rtl/ps2_kbd_pkg.sv
// Shared types and PS/2 Set-2 byte constants for the keyboard controller.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        SETTLE,
        EMIT
    } state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic       rpt;
        logic [7:0] code;
    } kbd_evt_t;

    // Bytes that are swallowed without disturbing pending prefix state.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_PAUSE) || (b == PS2_BAT) || (b == PS2_ACK) ||
               (b == PS2_ECHO)  || (b == PS2_RESEND);
    endfunction

endpackage

// File: rtl/ps2_kbd_ctrl.sv
// Drains the PS/2 receiver FIFO, folds E0/F0 prefixes into key events,
// tracks the held key for typematic detection and presents events on a
// valid/ready interface.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter bit              SUPPRESS_REPEAT = 1'b1,
    parameter int unsigned     TO_W            = 20,
    parameter logic [TO_W-1:0] TO_CYCLES       = 20'd1000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    input  logic       kbd_overflow,
    output logic       kbd_nextdata_n,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_repeat,
    output logic [7:0] press_cnt,
    output logic       err
);

    state_t          state_q, state_d;
    logic [7:0]      byte_q, byte_d;
    logic            ext_q, ext_d;
    logic            brk_q, brk_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            held_valid_q, held_valid_d;
    logic [8:0]      held_code_q, held_code_d;
    kbd_evt_t        evt_q, evt_d;
    logic [7:0]      press_cnt_q, press_cnt_d;
    logic            err_q, err_d;

    logic held_match;
    logic is_rpt;

    assign held_match = held_valid_q && (held_code_q == {ext_q, byte_q});
    assign is_rpt     = !brk_q && held_match;

    // Pop strobe decoded straight from the state register.
    assign kbd_nextdata_n = (state_q != POP);
    assign evt_valid      = (state_q == EMIT);
    assign evt_code       = evt_q.code;
    assign evt_ext        = evt_q.ext;
    assign evt_break      = evt_q.brk;
    assign evt_repeat     = evt_q.rpt;
    assign press_cnt      = press_cnt_q;
    assign err            = err_q;

    // Next-state, prefix decoding, held-key tracking and prefix timeout.
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        to_cnt_d     = to_cnt_q;
        held_valid_d = held_valid_q;
        held_code_d  = held_code_q;
        evt_d        = evt_q;
        press_cnt_d  = press_cnt_q;
        err_d        = err_q | kbd_overflow;

        case (state_q)
            IDLE: begin
                if (kbd_ready) begin
                    byte_d  = kbd_data;
                    state_d = POP;
                end else if (ext_q || brk_q) begin
                    if (to_cnt_q == TO_CYCLES - 1'b1) begin
                        ext_d    = 1'b0;
                        brk_d    = 1'b0;
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            POP: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                state_d = IDLE;
                if (byte_q == PS2_EXT) begin
                    ext_d    = 1'b1;
                    to_cnt_d = '0;
                end else if (byte_q == PS2_BRK) begin
                    brk_d    = 1'b1;
                    to_cnt_d = '0;
                end else if (is_discard(byte_q)) begin
                    state_d = IDLE;
                end else if ((byte_q == PS2_ERR0) || (byte_q == PS2_ERR1)) begin
                    err_d    = 1'b1;
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                    to_cnt_d = '0;
                end else begin
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                    to_cnt_d = '0;
                    if (brk_q) begin
                        if (held_match) begin
                            held_valid_d = 1'b0;
                        end
                    end else if (!is_rpt) begin
                        held_code_d  = {ext_q, byte_q};
                        held_valid_d = 1'b1;
                        press_cnt_d  = press_cnt_q + 8'd1;
                    end
                    if (!(is_rpt && SUPPRESS_REPEAT)) begin
                        evt_d   = '{ext: ext_q, brk: brk_q, rpt: is_rpt, code: byte_q};
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (evt_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            byte_q       <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            to_cnt_q     <= '0;
            held_valid_q <= 1'b0;
            held_code_q  <= '0;
            evt_q        <= '0;
            press_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            to_cnt_q     <= to_cnt_d;
            held_valid_q <= held_valid_d;
            held_code_q  <= held_code_d;
            evt_q        <= evt_d;
            press_cnt_q  <= press_cnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench: two controllers (repeat suppressed / repeat emitted)
// each fed by a behavioural receiver FIFO, events checked by scoreboard.
module tb_ps2_kbd_ctrl;
    import ps2_kbd_pkg::*;

    logic clk = 1'b0;
    logic clrn = 1'b0;

    logic [7:0] kbd_data0 = '0, kbd_data1 = '0;
    logic       kbd_ready0 = 1'b0, kbd_ready1 = 1'b0;
    logic       kbd_overflow0 = 1'b0, kbd_overflow1 = 1'b0;
    logic       kbd_nextdata_n0, kbd_nextdata_n1;
    logic       evt_valid0, evt_valid1;
    logic       evt_ready0 = 1'b1, evt_ready1 = 1'b1;
    logic [7:0] evt_code0, evt_code1;
    logic       evt_ext0, evt_ext1, evt_break0, evt_break1, evt_repeat0, evt_repeat1;
    logic [7:0] press_cnt0, press_cnt1;
    logic       err0, err1;

    logic [7:0] fifo0[$];
    logic [7:0] fifo1[$];
    kbd_evt_t   exp0[$];
    kbd_evt_t   exp1[$];

    int checks = 0;
    int errors = 0;
    int pops0 = 0, pops1 = 0, evts0 = 0, evts1 = 0;
    logic prev_pop0 = 1'b0, prev_pop1 = 1'b0;

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(.SUPPRESS_REPEAT(1'b1), .TO_W(20), .TO_CYCLES(20'd16)) u_dut0 (
        .clk(clk), .clrn(clrn), .kbd_data(kbd_data0), .kbd_ready(kbd_ready0),
        .kbd_overflow(kbd_overflow0), .kbd_nextdata_n(kbd_nextdata_n0),
        .evt_valid(evt_valid0), .evt_ready(evt_ready0), .evt_code(evt_code0),
        .evt_ext(evt_ext0), .evt_break(evt_break0), .evt_repeat(evt_repeat0),
        .press_cnt(press_cnt0), .err(err0)
    );

    ps2_kbd_ctrl #(.SUPPRESS_REPEAT(1'b0), .TO_W(20), .TO_CYCLES(20'd16)) u_dut1 (
        .clk(clk), .clrn(clrn), .kbd_data(kbd_data1), .kbd_ready(kbd_ready1),
        .kbd_overflow(kbd_overflow1), .kbd_nextdata_n(kbd_nextdata_n1),
        .evt_valid(evt_valid1), .evt_ready(evt_ready1), .evt_code(evt_code1),
        .evt_ext(evt_ext1), .evt_break(evt_break1), .evt_repeat(evt_repeat1),
        .press_cnt(press_cnt1), .err(err1)
    );

    function automatic kbd_evt_t mk(input logic e, input logic b, input logic r, input logic [7:0] c);
        return '{ext: e, brk: b, rpt: r, code: c};
    endfunction

    // One clock: score the handshake the coming edge will take, then move
    // to the next falling edge and update the receiver FIFO models.
    task automatic tick();
        kbd_evt_t got;
        kbd_evt_t want;
        if (evt_valid0 && evt_ready0) begin
            got = mk(evt_ext0, evt_break0, evt_repeat0, evt_code0);
            evts0++;
            checks++;
            if (exp0.size() == 0) begin
                errors++;
                $display("FAIL evt0_unexpected: got %h, expected none", got);
            end else begin
                want = exp0.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL evt0_fields: got %h, expected %h", got, want);
                end
            end
        end
        if (evt_valid1 && evt_ready1) begin
            got = mk(evt_ext1, evt_break1, evt_repeat1, evt_code1);
            evts1++;
            checks++;
            if (exp1.size() == 0) begin
                errors++;
                $display("FAIL evt1_unexpected: got %h, expected none", got);
            end else begin
                want = exp1.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL evt1_fields: got %h, expected %h", got, want);
                end
            end
        end
        @(negedge clk);
        if (kbd_nextdata_n0 === 1'b0) begin
            if (fifo0.size() == 0 || prev_pop0) begin
                errors++;
                $display("FAIL pop0_illegal: fifo size %0d, prev pop %0b", fifo0.size(), prev_pop0);
            end
            if (fifo0.size() != 0) void'(fifo0.pop_front());
            pops0++;
        end
        if (kbd_nextdata_n1 === 1'b0) begin
            if (fifo1.size() == 0 || prev_pop1) begin
                errors++;
                $display("FAIL pop1_illegal: fifo size %0d, prev pop %0b", fifo1.size(), prev_pop1);
            end
            if (fifo1.size() != 0) void'(fifo1.pop_front());
            pops1++;
        end
        prev_pop0  = (kbd_nextdata_n0 === 1'b0);
        prev_pop1  = (kbd_nextdata_n1 === 1'b0);
        kbd_ready0 = (fifo0.size() != 0);
        kbd_data0  = kbd_ready0 ? fifo0[0] : 8'h00;
        kbd_ready1 = (fifo1.size() != 0);
        kbd_data1  = kbd_ready1 ? fifo1[0] : 8'h00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(fifo0.size() == 0 && exp0.size() == 0 && !evt_valid0 && kbd_nextdata_n0 &&
                 fifo1.size() == 0 && exp1.size() == 0 && !evt_valid1 && kbd_nextdata_n1) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_timeout: pending fifo0=%0d exp0=%0d fifo1=%0d exp1=%0d, expected 0",
                     fifo0.size(), exp0.size(), fifo1.size(), exp1.size());
        end
        repeat (10) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({kbd_nextdata_n0, evt_valid0, evt_code0, evt_ext0, evt_break0, evt_repeat0, press_cnt0, err0}
            !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got nd=%b v=%b code=%h e=%b b=%b r=%b cnt=%h err=%b, expected 1 0 00 0 0 0 00 0",
                     kbd_nextdata_n0, evt_valid0, evt_code0, evt_ext0, evt_break0, evt_repeat0, press_cnt0, err0);
        end
        clrn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_make_break();
        int p, e;
        p = pops0; e = evts0;
        fifo0.push_back(8'h1C); fifo0.push_back(8'hF0); fifo0.push_back(8'h1C);
        exp0.push_back(mk(1'b0, 1'b0, 1'b0, 8'h1C));
        exp0.push_back(mk(1'b0, 1'b1, 1'b0, 8'h1C));
        drain();
        checks++;
        if (pops0 - p !== 3) begin errors++; $display("FAIL mb_pops: got %0d, expected 3", pops0 - p); end
        checks++;
        if (evts0 - e !== 2) begin errors++; $display("FAIL mb_events: got %0d, expected 2", evts0 - e); end
        checks++;
        if (press_cnt0 !== 8'd1) begin errors++; $display("FAIL mb_press_cnt: got %0d, expected 1", press_cnt0); end
    endtask

    task automatic test_extended();
        int p, e;
        p = pops0; e = evts0;
        fifo0.push_back(8'hE0); fifo0.push_back(8'h75);
        fifo0.push_back(8'hE0); fifo0.push_back(8'hF0); fifo0.push_back(8'h75);
        exp0.push_back(mk(1'b1, 1'b0, 1'b0, 8'h75));
        exp0.push_back(mk(1'b1, 1'b1, 1'b0, 8'h75));
        drain();
        checks++;
        if (pops0 - p !== 5) begin errors++; $display("FAIL ext_pops: got %0d, expected 5", pops0 - p); end
        checks++;
        if (evts0 - e !== 2) begin errors++; $display("FAIL ext_events: got %0d, expected 2", evts0 - e); end
        checks++;
        if (press_cnt0 !== 8'd2) begin errors++; $display("FAIL ext_press_cnt: got %0d, expected 2", press_cnt0); end
    endtask

    task automatic test_repeat();
        int e0, e1;
        logic [7:0] seq [5];
        e0 = evts0; e1 = evts1;
        seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        for (int i = 0; i < 5; i++) begin
            fifo0.push_back(seq[i]);
            fifo1.push_back(seq[i]);
        end
        exp0.push_back(mk(1'b0, 1'b0, 1'b0, 8'h1C));
        exp0.push_back(mk(1'b0, 1'b1, 1'b0, 8'h1C));
        exp1.push_back(mk(1'b0, 1'b0, 1'b0, 8'h1C));
        exp1.push_back(mk(1'b0, 1'b0, 1'b1, 8'h1C));
        exp1.push_back(mk(1'b0, 1'b0, 1'b1, 8'h1C));
        exp1.push_back(mk(1'b0, 1'b1, 1'b0, 8'h1C));
        drain();
        checks++;
        if (evts0 - e0 !== 2) begin errors++; $display("FAIL rep_sup_events: got %0d, expected 2", evts0 - e0); end
        checks++;
        if (evts1 - e1 !== 4) begin errors++; $display("FAIL rep_emit_events: got %0d, expected 4", evts1 - e1); end
        checks++;
        if (press_cnt0 !== 8'd3) begin errors++; $display("FAIL rep_sup_press_cnt: got %0d, expected 3", press_cnt0); end
        checks++;
        if (press_cnt1 !== 8'd1) begin errors++; $display("FAIL rep_emit_press_cnt: got %0d, expected 1", press_cnt1); end
    endtask

    task automatic test_back_to_back();
        int p, n;
        kbd_evt_t held;
        p = pops0;
        evt_ready0 = 1'b0;
        fifo0.push_back(8'h12); fifo0.push_back(8'h13); fifo0.push_back(8'h14);
        exp0.push_back(mk(1'b0, 1'b0, 1'b0, 8'h12));
        exp0.push_back(mk(1'b0, 1'b0, 1'b0, 8'h13));
        exp0.push_back(mk(1'b0, 1'b0, 1'b0, 8'h14));
        n = 0;
        while (!evt_valid0 && n < 50) begin tick(); n++; end
        held = mk(evt_ext0, evt_break0, evt_repeat0, evt_code0);
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (!evt_valid0 || mk(evt_ext0, evt_break0, evt_repeat0, evt_code0) !== mk(1'b0, 1'b0, 1'b0, 8'h12)) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b evt=%h (first seen %h), expected valid=1 evt=%h",
                         evt_valid0, mk(evt_ext0, evt_break0, evt_repeat0, evt_code0), held,
                         mk(1'b0, 1'b0, 1'b0, 8'h12));
            end
        end
        checks++;
        if (pops0 - p !== 1) begin errors++; $display("FAIL bp_pops: got %0d, expected 1", pops0 - p); end
        evt_ready0 = 1'b1;
        drain();
        checks++;
        if (press_cnt0 !== 8'd6) begin errors++; $display("FAIL bp_press_cnt: got %0d, expected 6", press_cnt0); end
    endtask

    task automatic test_timeout_and_errors();
        int e, n;
        fifo0.push_back(8'hF0);
        n = 0;
        while ((fifo0.size() != 0 || !kbd_nextdata_n0) && n < 50) begin tick(); n++; end
        repeat (20) tick();
        fifo0.push_back(8'h2B);
        exp0.push_back(mk(1'b0, 1'b0, 1'b0, 8'h2B));
        drain();
        checks++;
        if (press_cnt0 !== 8'd7) begin errors++; $display("FAIL to_press_cnt: got %0d, expected 7", press_cnt0); end

        e = evts0;
        fifo0.push_back(8'hFA);
        drain();
        checks++;
        if (evts0 - e !== 0) begin errors++; $display("FAIL ack_events: got %0d, expected 0", evts0 - e); end
        checks++;
        if (err0 !== 1'b0) begin errors++; $display("FAIL ack_err: got %b, expected 0", err0); end

        fifo0.push_back(8'hFF);
        drain();
        checks++;
        if (err0 !== 1'b1) begin errors++; $display("FAIL errbyte_err: got %b, expected 1", err0); end
        checks++;
        if (evts0 - e !== 0) begin errors++; $display("FAIL errbyte_events: got %0d, expected 0", evts0 - e); end
    endtask

    task automatic test_reset_mid_event();
        int n;
        evt_ready0 = 1'b0;
        fifo0.push_back(8'h1B);
        n = 0;
        while (!evt_valid0 && n < 50) begin tick(); n++; end
        checks++;
        if (evt_valid0 !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b, expected 1", evt_valid0); end
        #2;
        clrn = 1'b0;
        #1;
        checks++;
        if (evt_valid0 !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b, expected 0", evt_valid0); end
        checks++;
        if (press_cnt0 !== 8'd0) begin errors++; $display("FAIL rst_async_press_cnt: got %0d, expected 0", press_cnt0); end
        checks++;
        if (err0 !== 1'b0) begin errors++; $display("FAIL rst_async_err: got %b, expected 0", err0); end
        exp0.delete();
        repeat (2) tick();
        clrn = 1'b1;
        evt_ready0 = 1'b1;
        tick();
        fifo0.push_back(8'h29);
        exp0.push_back(mk(1'b0, 1'b0, 1'b0, 8'h29));
        drain();
        checks++;
        if (press_cnt0 !== 8'd1) begin errors++; $display("FAIL rst_after_press_cnt: got %0d, expected 1", press_cnt0); end
    endtask

    task automatic test_overflow();
        checks++;
        if (err0 !== 1'b0) begin errors++; $display("FAIL ovf_pre_err: got %b, expected 0", err0); end
        kbd_overflow0 = 1'b1;
        tick();
        kbd_overflow0 = 1'b0;
        repeat (3) tick();
        checks++;
        if (err0 !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b, expected 1", err0); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_repeat();
        test_back_to_back();
        test_timeout_and_errors();
        test_reset_mid_event();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
